// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the RAM built-in self-test controller.
//   - default RAM geometry and base data pattern
//   - march FSM state encoding
//   - phase codes reported through fail_phase
package ram_pkg;

    localparam int          ADDER_WIDTH_DEF = 4;
    localparam int          MEM_WIDTH_DEF   = 16;
    localparam int          MEM_DEPTH_DEF   = 8;
    localparam logic [15:0] PATTERN_DEF     = 16'hA5A5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR_UP = 3'd1,
        S_RD_UP = 3'd2,
        S_WR_DN = 3'd3,
        S_RD_DN = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [1:0] PH_WR_UP = 2'd0;
    localparam logic [1:0] PH_RD_UP = 2'd1;
    localparam logic [1:0] PH_WR_DN = 2'd2;
    localparam logic [1:0] PH_RD_DN = 2'd3;

endpackage

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen: loadable up/down address counter for the BIST march.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-low reset
//   load/load_value load the counter (takes priority over step)
//   step/up         advance one address in the selected direction
//   count           current address
//   last            terminal count: MEM_DEPTH-1 when counting up, 0 when down
module ram_bist_addr_gen #(
    parameter int ADDER_WIDTH = 4,
    parameter int MEM_DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [ADDER_WIDTH-1:0] load_value,
    input  logic                   step,
    input  logic                   up,
    output logic [ADDER_WIDTH-1:0] count,
    output logic                   last
);

    localparam logic [ADDER_WIDTH-1:0] LAST_ADDR = ADDER_WIDTH'(MEM_DEPTH - 1);

    assign last = up ? (count == LAST_ADDR) : (count == '0);

    // Stepping is suppressed at the terminal count so the sweep never wraps
    // past MEM_DEPTH-1 or underflows below 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (step && !last) begin
            count <= up ? count + 1'b1 : count - 1'b1;
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march-test BIST master for a single-port RAM.
// Sequence: write E(a) up, read/compare up, write ~E(a) down, read/compare
// down, one drain cycle, then DONE. E(a) = PATTERN ^ zero-extended a.
// Ports:
//   clk, rst                clock (rising edge), synchronous active-low reset
//   start                   begin a test (accepted in IDLE or DONE only)
//   busy, done, pass        run status; pass valid while done=1
//   fail_addr/phase/data    first mismatch, sticky until next start/reset
//   wren, rden, addr, wr_data  RAM access drive
//   rd_data                 RAM read data, one cycle after the read
// Optional build macro RAM_BIST_STOP_ON_FAIL_EN: abort to DONE on the
// first mismatch instead of completing the march.
module ram_bist_ctrl
    import ram_pkg::*;
#(
    parameter int                   ADDER_WIDTH = ADDER_WIDTH_DEF,
    parameter int                   MEM_WIDTH   = MEM_WIDTH_DEF,
    parameter int                   MEM_DEPTH   = MEM_DEPTH_DEF,
    parameter logic [MEM_WIDTH-1:0] PATTERN     = MEM_WIDTH'(PATTERN_DEF)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ADDER_WIDTH-1:0] fail_addr,
    output logic [1:0]             fail_phase,
    output logic [MEM_WIDTH-1:0]   fail_data,
    output logic                   wren,
    output logic                   rden,
    output logic [ADDER_WIDTH-1:0] addr,
    output logic [MEM_WIDTH-1:0]   wr_data,
    input  logic [MEM_WIDTH-1:0]   rd_data
);

    localparam logic [ADDER_WIDTH-1:0] LAST_ADDR = ADDER_WIDTH'(MEM_DEPTH - 1);

    function automatic logic [MEM_WIDTH-1:0] exp_data(input logic [ADDER_WIDTH-1:0] a);
        return PATTERN ^ MEM_WIDTH'(a);
    endfunction

    state_t                 state_q, state_d;
    logic                   cnt_load, cnt_step, cnt_up, cnt_last;
    logic [ADDER_WIDTH-1:0] cnt_load_value, cnt;
    logic                   vld_p1;
    logic [ADDER_WIDTH-1:0] addr_p1;
    logic [MEM_WIDTH-1:0]   exp_p1;
    logic [1:0]             phase_p1;
    logic                   mismatch;
    logic                   fail_seen;
    logic                   accept_start;

    ram_bist_addr_gen #(
        .ADDER_WIDTH (ADDER_WIDTH),
        .MEM_DEPTH   (MEM_DEPTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .step       (cnt_step),
        .up         (cnt_up),
        .count      (cnt),
        .last       (cnt_last)
    );

    assign accept_start = start && (state_q == S_IDLE || state_q == S_DONE);
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign pass         = done && !fail_seen;
    assign mismatch     = vld_p1 && (rd_data != exp_p1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_step       = 1'b0;
        cnt_up         = 1'b1;
        wren           = 1'b0;
        rden           = 1'b0;
        addr           = '0;
        wr_data        = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_WR_UP;
                    cnt_load = 1'b1;
                end
            end
            S_WR_UP: begin
                wren    = 1'b1;
                addr    = cnt;
                wr_data = exp_data(cnt);
                if (cnt_last) begin
                    state_d  = S_RD_UP;
                    cnt_load = 1'b1;
                end else begin
                    cnt_step = 1'b1;
                end
            end
            S_RD_UP: begin
                rden = 1'b1;
                addr = cnt;
                if (cnt_last) begin
                    state_d        = S_WR_DN;
                    cnt_load       = 1'b1;
                    cnt_load_value = LAST_ADDR;
                end else begin
                    cnt_step = 1'b1;
                end
            end
            S_WR_DN: begin
                cnt_up  = 1'b0;
                wren    = 1'b1;
                addr    = cnt;
                wr_data = ~exp_data(cnt);
                if (cnt_last) begin
                    state_d        = S_RD_DN;
                    cnt_load       = 1'b1;
                    cnt_load_value = LAST_ADDR;
                end else begin
                    cnt_step = 1'b1;
                end
            end
            S_RD_DN: begin
                cnt_up = 1'b0;
                rden   = 1'b1;
                addr   = cnt;
                if (cnt_last) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_step = 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef RAM_BIST_STOP_ON_FAIL_EN
        // A mismatch seen while running kills the current access in the
        // same cycle and ends the march.
        if (mismatch && busy) begin
            state_d  = S_DONE;
            cnt_load = 1'b0;
            cnt_step = 1'b0;
            wren     = 1'b0;
            rden     = 1'b0;
            addr     = '0;
            wr_data  = '0;
        end
`endif
    end

    // ---- stage p1: remember what the in-flight read must return ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rden;
        end
    end

    always_ff @(posedge clk) begin
        addr_p1  <= addr;
        exp_p1   <= (state_q == S_RD_DN) ? ~exp_data(addr) : exp_data(addr);
        phase_p1 <= (state_q == S_RD_DN) ? PH_RD_DN : PH_RD_UP;
    end

    // ---- stage p2: compare rd_data, latch only the first failure ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            fail_seen  <= 1'b0;
            fail_addr  <= '0;
            fail_phase <= '0;
            fail_data  <= '0;
        end else if (accept_start) begin
            fail_seen  <= 1'b0;
            fail_addr  <= '0;
            fail_phase <= '0;
            fail_data  <= '0;
        end else if (mismatch && !fail_seen) begin
            fail_seen  <= 1'b1;
            fail_addr  <= addr_p1;
            fail_phase <= phase_p1;
            fail_data  <= rd_data;
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: self-checking bench for ram_bist_ctrl with a behavioural
// single-port RAM that can force one bit of one address to read as 0.
module tb_ram_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, pass;
    logic [3:0]  fail_addr;
    logic [1:0]  fail_phase;
    logic [15:0] fail_data;
    logic        wren, rden;
    logic [3:0]  addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data = 16'h0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] data;
    } acc_t;

    acc_t        exp_q[$];
    acc_t        mon_e;
    bit          sb_on = 1'b0;
    int          wr_count = 0;

    logic [15:0] mem [0:15];
    bit          fault_en = 1'b0;
    logic [3:0]  fault_addr = 4'h0;
    logic [15:0] fault_mask = 16'h0;

    always #5 clk = ~clk;

    ram_bist_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_phase (fail_phase),
        .fail_data  (fail_data),
        .wren       (wren),
        .rden       (rden),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data)
    );

    always @(posedge clk) begin
        if (wren) mem[addr] <= wr_data;
        if (rden) rd_data <= (fault_en && addr == fault_addr) ? (mem[addr] & ~fault_mask) : mem[addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_e(input int a);
        logic [15:0] p;
        p = 16'hA5A5;
        return p ^ 16'(a);
    endfunction

    task automatic push_march();
        for (int a = 0; a < 8; a++) exp_q.push_back('{1'b1, 4'(a), model_e(a)});
        for (int a = 0; a < 8; a++) exp_q.push_back('{1'b0, 4'(a), 16'h0});
        for (int a = 7; a >= 0; a--) exp_q.push_back('{1'b1, 4'(a), ~model_e(a)});
        for (int a = 7; a >= 0; a--) exp_q.push_back('{1'b0, 4'(a), 16'h0});
    endtask

    // Bus monitor: exclusivity, idle bus values, and scoreboard of accesses.
    always @(negedge clk) begin
        if (rst) begin
            check_val("excl", 32'(wren & rden), 32'h0);
            if (!wren && !rden) check_val("idle_bus", {addr, wr_data}, 32'h0);
        end
        if (wren) wr_count++;
        if (sb_on && (wren || rden)) begin
            if (exp_q.size() == 0) begin
                check_val("sb_extra", {wren, rden, addr, wr_data}, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("sb_acc", {wren, addr, wr_data}, {mon_e.wr, mon_e.addr, mon_e.data});
            end
        end
    end

    task automatic run_test(input bit hold_start, output int n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        check_val("done_rise", 32'(done), 32'h1);
    endtask

    task automatic check_result(input string tag, input logic p, input logic [3:0] fa,
                                input logic [1:0] fp, input logic [15:0] fd);
        check_val({tag, "_pass"}, 32'(pass), 32'(p));
        check_val({tag, "_faddr"}, 32'(fail_addr), 32'(fa));
        check_val({tag, "_fphase"}, 32'(fail_phase), 32'(fp));
        check_val({tag, "_fdata"}, 32'(fail_data), 32'(fd));
    endtask

    initial begin
        int n;
        int k;
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_status", {busy, done, pass, wren, rden}, 32'h0);
        check_result("rst", 1'b0, 4'h0, 2'd0, 16'h0);
        @(negedge clk);
        rst = 1'b1;

        // Healthy RAM, full access sequence scoreboarded
        push_march();
        wr_count = 0;
        sb_on = 1'b1;
        run_test(1'b0, n);
        sb_on = 1'b0;
        check_val("ok_busy_cycles", 32'(n), 32'd33);
        check_result("ok", 1'b1, 4'h0, 2'd0, 16'h0);
        check_val("ok_sb_empty", 32'(exp_q.size()), 32'h0);
        check_val("ok_wr_count", 32'(wr_count), 32'd16);

        // addr 5 bit 0 stuck-at-0: only the down read sees it
        fault_en = 1'b1; fault_addr = 4'd5; fault_mask = 16'h0001;
        run_test(1'b0, n);
`ifdef RAM_BIST_STOP_ON_FAIL_EN
        check_val("sa5_busy_cycles", 32'(n), 32'd28);
`else
        check_val("sa5_busy_cycles", 32'(n), 32'd33);
`endif
        check_result("sa5", 1'b0, 4'd5, 2'd3, 16'h5A5E);

        // addr 2 bit 15 stuck-at-0: caught in the up read
        fault_addr = 4'd2; fault_mask = 16'h8000;
        wr_count = 0;
        run_test(1'b0, n);
`ifdef RAM_BIST_STOP_ON_FAIL_EN
        check_val("sa2_busy_cycles", 32'(n), 32'd12);
        check_val("sa2_wr_count", 32'(wr_count), 32'd8);
`else
        check_val("sa2_busy_cycles", 32'(n), 32'd33);
        check_val("sa2_wr_count", 32'(wr_count), 32'd16);
`endif
        check_result("sa2", 1'b0, 4'd2, 2'd1, 16'h25A7);

        // Reset in RD_UP after a failure was captured
        fault_addr = 4'd0; fault_mask = 16'h0001;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check_val("mid_fphase", 32'(fail_phase), 32'd1);
        check_val("mid_fdata", 32'(fail_data), 32'h0000A5A4);
`ifndef RAM_BIST_STOP_ON_FAIL_EN
        check_val("mid_rden", 32'(rden), 32'h1);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("mrst_status", {busy, done, pass, wren, rden}, 32'h0);
        check_result("mrst", 1'b0, 4'h0, 2'd0, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        fault_en = 1'b0;
        push_march();
        sb_on = 1'b1;
        run_test(1'b0, n);
        sb_on = 1'b0;
        check_val("rerun_busy_cycles", 32'(n), 32'd33);
        check_result("rerun", 1'b1, 4'h0, 2'd0, 16'h0);
        check_val("rerun_sb_empty", 32'(exp_q.size()), 32'h0);

        // start held high: ignored while busy, restarts from DONE
        run_test(1'b1, n);
        check_val("hold_busy_cycles", 32'(n), 32'd33);
        check_val("hold_pass", 32'(pass), 32'h1);
        @(posedge clk); #1;
        check_val("hold_restart", {busy, done}, 32'h2);
        start = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            k++;
            @(posedge clk); #1;
        end
        check_val("hold_rerun_cycles", 32'(k), 32'd33);
        check_val("hold_rerun_pass", 32'(pass), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
Built-in self-test master for the single-port RAM: drives the RAM's wr_data/addr/wren/rden and checks rd_data.
- Runs a four-phase march (write up, read/compare up, write inverse down, read/compare down) over addresses 0..MEM_DEPTH-1.
- Reports pass/fail plus the first failing address, phase and read value.
- Sits between the RAM and system control; start/done are driven by a sequencer or testbench.

Parameters:
ADDER_WIDTH, 4, RAM address width.
MEM_WIDTH, 16, RAM data width.
MEM_DEPTH, 8, number of addresses swept (must be <= 2**ADDER_WIDTH).
PATTERN, 16'hA5A5, base data pattern (MEM_WIDTH bits).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous active-low reset.
start  input  1  begin test; sampled only when not busy.
busy  output  1  high while the march runs.
done  output  1  high from test end until the next accepted start.
pass  output  1  valid while done=1; 1 = no mismatch.
fail_addr  output  ADDER_WIDTH  address of the first mismatch.
fail_phase  output  2  phase of the first mismatch (1 = RD_UP, 3 = RD_DN).
fail_data  output  MEM_WIDTH  rd_data captured at the first mismatch.
wren  output  1  RAM write enable.
rden  output  1  RAM read enable.
addr  output  ADDER_WIDTH  RAM address.
wr_data  output  MEM_WIDTH  RAM write data.
rd_data  input  MEM_WIDTH  RAM read data, registered, valid the cycle after rden/addr are sampled.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; all outputs 0.
  - Valid mid-run: wren/rden drop at that edge, no further RAM access, captured failure info is cleared.
- Expected data: E(a) = PATTERN ^ zero-extended a.
- States: IDLE, WR_UP, RD_UP, WR_DN, RD_DN, DRAIN, DONE.
- Start:
  - start=1 at edge E in IDLE or DONE -> WR_UP, address counter=0, done=0, pass=0, failure info cleared.
  - start while busy is ignored.
- WR_UP: wren=1, addr=a, wr_data=E(a), a=0..MEM_DEPTH-1, one address per cycle; after the last address -> RD_UP, a=0.
- RD_UP: rden=1, addr ascending. The compare against E(a) happens one cycle later using a delayed expected value and delayed address. The final compare overlaps the first WR_DN cycle.
- WR_DN: wren=1, addr descending from MEM_DEPTH-1 to 0, wr_data=~E(a).
- RD_DN: rden=1, addr descending; compare against ~E(a) one cycle later.
- DRAIN: one cycle with no RAM access, performs the final compare.
- DONE: done=1 and busy=0; pass=1 iff no mismatch was recorded.
- Timing: busy=1 during cycles E+1..E+4*MEM_DEPTH+1; done rises after edge E+4*MEM_DEPTH+1 (33 cycles for depth 8).
- wren and rden are never both 1. When neither is active, addr and wr_data hold 0.
- First-fail capture: fail_addr/fail_phase/fail_data latch on the first mismatch only and are sticky until the next start or reset. Later mismatches are ignored.
- Address counter is exact-range: no wrap beyond MEM_DEPTH-1; the down sweep terminates at 0 without underflow.

Optional Feature:
RAM_BIST_STOP_ON_FAIL_EN
- Defined: a mismatch aborts the march. The next state is DONE with pass=0, wren/rden drop immediately, and any remaining accesses are skipped.
- Undefined: the march always runs to completion and total latency is fixed.

Decomposition:
- Package ram_pkg:
  - default ADDER_WIDTH/MEM_WIDTH/MEM_DEPTH;
  - state enum encoding;
  - phase codes (0 WR_UP, 1 RD_UP, 2 WR_DN, 3 RD_DN);
  - PATTERN default.
- One sub-module, ram_bist_addr_gen: loadable up/down counter with a terminal-count flag.
- FSM and compare pipeline stay in ram_bist_ctrl.

Test Plan:
- Healthy RAM model, depth 8, start pulse -> busy 33 cycles, then done=1, pass=1, fail_addr=0, fail_phase=0, fail_data=0.
- Monitor during WR_UP -> writes addr 0..7 with data 16'hA5A5..16'hA5A2; during WR_DN -> addr 7..0 with data 16'h5A5D..16'h5A5A.
- Bit 0 of addr 5 stuck-at-0 in the RAM model -> pass=0, fail_addr=5, fail_phase=3, fail_data=16'h5A5E; RD_UP passes, since 16'hA5A0 has bit 0 = 0.
- Bit 15 of addr 2 stuck-at-0 -> fail_phase=1, fail_addr=2, fail_data=16'h25A7. With the macro defined, done follows within 2 cycles of the bad read and WR_DN never occurs.
- rst=0 during RD_UP -> next cycle wren=rden=busy=done=0; a new start reruns the full 33-cycle march and passes.
- start held high through the run and into DONE -> no restart while busy; a restart happens at the first DONE edge with start=1.
